// File: rtl/fifo_ctrl.sv
// Write arbiter and read sequencer around an 8-entry byte FIFO (7 usable words).
// Build option: define FIFO_CTRL_WATERMARK_EN to throttle writes at AF_LEVEL words.
module fifo_ctrl #(
  parameter int DW       = 8,
  parameter int AF_LEVEL = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_din,
  input  logic          fifo_full,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_dout,
  input  logic          fifo_empty,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic [3:0]    occupancy,
  output logic          almost_full,
  output logic [15:0]   xfer_count
);

  localparam logic [3:0] MAX_OCC = 4'd7;
  localparam logic [3:0] AF_LVL  = 4'(AF_LEVEL);

`ifdef FIFO_CTRL_WATERMARK_EN
  localparam bit WM_EN = 1'b1;
`else
  localparam bit WM_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        rr_ptr;
  logic [3:0]  occ_q;
  logic        throttle;
  logic        wr_ok;

  assign occupancy   = occ_q;
  assign almost_full = WM_EN && (occ_q >= AF_LVL);
  assign throttle    = almost_full;
  assign wr_ok       = ~fifo_full & ~throttle;

  // Round-robin only matters when both producers ask in the same cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && wr_ok) begin
      if (req0 && req1) begin
        if (rr_ptr) gnt1 = 1'b1;
        else        gnt0 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    fifo_wr_en = gnt0 | gnt1;
    if (gnt0)      fifo_din = data0;
    else if (gnt1) fifo_din = data1;
    else           fifo_din = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    rr_ptr <= 1'b0;
    else if (gnt0) rr_ptr <= 1'b1;
    else if (gnt1) rr_ptr <= 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: state_d = HOLD;
      HOLD: begin
        if (m_ready) begin
          if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            state_d    = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) fifo_rd_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      m_valid    <= 1'b0;
      m_data     <= '0;
      xfer_count <= '0;
    end else begin
      state_q <= state_d;
      m_valid <= (state_d == HOLD);
      if (state_q == FETCH) m_data <= fifo_dout;
      if (state_q == HOLD && m_ready) xfer_count <= xfer_count + 16'd1;
    end
  end

  // Simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      case ({fifo_wr_en, fifo_rd_en})
        2'b10:   if (occ_q < MAX_OCC) occ_q <= occ_q + 4'd1;
        2'b01:   if (occ_q != 4'd0)   occ_q <= occ_q - 4'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl: behavioural FIFO, queue scoreboard and per-cycle rule checks.
module tb_fifo_ctrl;
  localparam int DW = 8;
  localparam int AF = 5;
`ifdef FIFO_CTRL_WATERMARK_EN
  localparam bit WM       = 1'b1;
  localparam int STOP_LVL = AF;
`else
  localparam bit WM       = 1'b0;
  localparam int STOP_LVL = 7;
`endif

  logic          clk, rst_n;
  logic          req0, req1, gnt0, gnt1;
  logic [DW-1:0] data0, data1;
  logic          fifo_wr_en, fifo_full, fifo_rd_en, fifo_empty;
  logic [DW-1:0] fifo_din, fifo_dout;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic [3:0]    occupancy;
  logic          almost_full;
  logic [15:0]   xfer_count;

  fifo_ctrl #(.DW(DW), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .occupancy(occupancy), .almost_full(almost_full), .xfer_count(xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural 8-slot FIFO with 7 usable words and registered read data.
  logic [DW-1:0] mem [8];
  logic [2:0]    wp, rp;
  logic [3:0]    cnt;
  logic          f_w, f_r;
  assign fifo_full  = (cnt == 4'd7);
  assign fifo_empty = (cnt == 4'd0);
  assign f_w = fifo_wr_en & ~fifo_full;
  assign f_r = fifo_rd_en & ~fifo_empty;

  always @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0; rp <= '0; cnt <= '0; fifo_dout <= '0;
    end else begin
      if (f_w) begin mem[wp] <= fifo_din; wp <= wp + 3'd1; end
      if (f_r) begin fifo_dout <= mem[rp]; rp <= rp + 3'd1; end
      cnt <= cnt + 4'(f_w) - 4'(f_r);
    end
  end

  // Reference model: preferred side, bytes owed to the consumer, handshake count.
  bit          exp_rr;
  byte         sb[$];
  int          exp_xfer;
  int          rx_total;
  bit          stalled;
  logic [7:0]  held;

  always @(negedge clk) begin
    bit eg0, eg1, ok;
    logic [7:0] exp_din;
    if (!rst_n) begin
      check("gnt_in_reset", {28'b0, gnt0, gnt1, fifo_wr_en, fifo_rd_en}, 32'd0);
      exp_rr = 1'b0;
      sb.delete();
      exp_xfer = 0;
      stalled = 1'b0;
    end else begin
      ok  = (cnt != 4'd7) && !(WM && cnt >= 4'(AF));
      eg0 = ok && req0 && (!req1 || !exp_rr);
      eg1 = ok && req1 && (!req0 || exp_rr);
      exp_din = eg0 ? data0 : (eg1 ? data1 : 8'h00);
      check("grant", {30'b0, gnt0, gnt1}, {30'b0, eg0, eg1});
      check("fifo_din", {24'b0, fifo_din}, {24'b0, exp_din});
      check("wr_when_full", {31'b0, fifo_wr_en & fifo_full}, 32'd0);
      check("rd_when_empty", {31'b0, fifo_rd_en & fifo_empty}, 32'd0);
      check("occupancy", {28'b0, occupancy}, {28'b0, cnt});
      check("almost_full", {31'b0, almost_full}, {31'b0, WM && (cnt >= 4'(AF))});
      check("xfer_count", {16'b0, xfer_count}, exp_xfer & 32'hFFFF);
      if (stalled) begin
        check("stall_valid", {31'b0, m_valid}, 32'd1);
        check("stall_data", {24'b0, m_data}, {24'b0, held});
      end
      if (m_valid && m_ready) begin
        check("byte_owed", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) check("rx_order", {24'b0, m_data}, {24'b0, sb.pop_front()});
        exp_xfer++;
        rx_total++;
      end
      if (eg0) begin sb.push_back(data0); exp_rr = 1'b1; end
      else if (eg1) begin sb.push_back(data1); exp_rr = 1'b0; end
      stalled = m_valid && !m_ready;
      held    = m_data;
    end
  end

  task automatic drain(input string tag);
    bit done = 1'b0;
    req0 = 1'b0; req1 = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !m_valid && occupancy == 4'd0) done = 1'b1;
    end
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_sb_left"}, sb.size(), 32'd0);
  endtask

  initial begin
    int edges, nw, x0, rx0, idx;
    bit g0, g1, seen;
    bit gseq [4];

    rx_total = 0;
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0; data0 = '0; data1 = '0; m_ready = 1'b0;

    // Reset held 3 cycles with a pending request
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_occ", {28'b0, occupancy}, 32'd0);
    check("rst_xfer", {16'b0, xfer_count}, 32'd0);
    req0 = 1'b0;
    rst_n = 1'b1;

    // Single byte latency; the write edge is the first of the three
    @(posedge clk); #1;
    req0 = 1'b1; data0 = 8'hA5; m_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (gnt0) seen = 1'b1;
    end
    check("t2_granted", {31'b0, seen}, 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    edges = 1;
    while (!m_valid && edges < 12) begin
      @(posedge clk); #1;
      edges++;
    end
    check("t2_latency", edges, 32'd3);
    check("t2_data", {24'b0, m_data}, 32'hA5);
    @(posedge clk); #1;
    check("t2_xfer", {16'b0, xfer_count}, 32'd1);
    check("t2_valid_drop", {31'b0, m_valid}, 32'd0);

    // Both producers, consumer stalled: fill to the stop level
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; m_ready = 1'b0;
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h10; data1 = 8'h20;
    nw = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (fifo_wr_en) begin
        if (nw < 4) gseq[nw] = gnt1;
        nw++;
      end
    end
    // One extra byte has moved out of the FIFO into the output register.
    check("t3_writes", nw, STOP_LVL + 1);
    check("t3_order", {28'b0, gseq[0], gseq[1], gseq[2], gseq[3]}, 32'b0101);
    check("t3_occ", {28'b0, occupancy}, STOP_LVL);
    check("t3_full", {31'b0, fifo_full}, {31'b0, STOP_LVL == 7});
    check("t3_af", {31'b0, almost_full}, {31'b0, WM});
    check("t3_hold", {23'b0, m_valid, m_data}, 32'h110);

    // Drain from the stop level with both producers still pushing
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("t4_occ_band", {31'b0, occupancy >= 4'(STOP_LVL - 1) && occupancy <= 4'(STOP_LVL)}, 32'd1);
      if (i == 9) x0 = xfer_count;
      if (i == 49) check("t4_throughput", xfer_count - x0[15:0], 32'd20);
    end
    drain("t4_drain");

    // 100 bytes via producer 1 against a randomly stalling consumer
    @(posedge clk); #1;
    rx0 = rx_total; x0 = xfer_count; idx = 0;
    req1 = 1'b1; data1 = 8'h00;
    for (int i = 0; i < 2000 && (idx < 100 || rx_total - rx0 < 100); i++) begin
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk); g1 = gnt1;
      @(posedge clk); #1;
      if (g1) idx++;
      req1 = (idx < 100);
      data1 = 8'(idx);
    end
    check("t5_rx", rx_total - rx0, 32'd100);
    check("t5_xfer", {16'b0, 16'(xfer_count - x0[15:0])}, 32'd100);
    drain("t5_drain");

    // Random traffic on both producers with a reset in the middle
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); g0 = gnt0; g1 = gnt1;
      @(posedge clk); #1;
      if (i == 151) begin
        check("midrst_occ", {28'b0, occupancy}, 32'd0);
        check("midrst_valid", {31'b0, m_valid}, 32'd0);
      end
      rst_n = (i != 150);
      if (!req0 || g0) begin req0 = 1'($urandom_range(0, 1)); data0 = 8'($urandom); end
      if (!req1 || g1) begin req1 = 1'($urandom_range(0, 1)); data1 = 8'($urandom); end
      m_ready = ($urandom_range(0, 3) != 0);
    end
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
